// File: rtl/clkdiv_sched_pkg.sv
// clkdiv_sched shared definitions.
// State encoding and default widths.
package clkdiv_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEF_CNT_W = 24;
  localparam int DEF_DIV   = 100;
  localparam int DEF_PER_W = 16;

endpackage

// File: rtl/clkdiv_core.sv
// Divide counter with equality compare.
// Toggles clk_out when count reaches div.
module clkdiv_core
  import clkdiv_sched_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] div,
  output logic             wrap,
  output logic             clk_out
);

  logic [CNT_W-1:0] r_count;
  logic             r_clk;

  assign wrap    = en && (r_count == div);
  assign clk_out = r_clk;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_clk   <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_clk   <= 1'b0;
    end else if (wrap) begin
      r_count <= '0;
      r_clk   <= ~r_clk;
    end else if (en) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/clkdiv_sched.sv
// Run/stop FSM and reconfiguration scheduler
// around clkdiv_core; applies new divides at toggles.
module clkdiv_sched
  import clkdiv_sched_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV,
  parameter int PER_W       = DEF_PER_W
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  input  logic             start,
  input  logic             stop,
  output logic             running,
  output logic             clk_out,
  output logic             tick,
  output logic [PER_W-1:0] periods
);

  state_t           r_state;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_pend_div;
  logic             r_pend_valid;
  logic             r_tick;
  logic [PER_W-1:0] r_periods;

  logic w_en;
  logic w_clr;
  logic w_wrap;
  logic w_clk;
  logic w_xfer;
  logic w_fall;

  // Stop seen with clk_out low parks at once: freeze the counter.
  assign w_en   = (r_state != ST_IDLE) &&
                  !(r_state == ST_RUN && stop && !w_clk);
  assign w_clr  = !w_en;
  assign w_xfer = cfg_valid && !r_pend_valid;
  assign w_fall = w_wrap && w_clk;

  clkdiv_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .en      (w_en),
    .clr     (w_clr),
    .div     (r_div),
    .wrap    (w_wrap),
    .clk_out (w_clk)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:
          if (start && !stop) r_state <= ST_RUN;
        ST_RUN:
          if (stop)
            r_state <= (!w_clk || w_wrap) ? ST_IDLE
                                           : ST_DRAIN;
        ST_DRAIN:
          if (w_fall) r_state <= ST_IDLE;
        default:
          r_state <= ST_IDLE;
      endcase
    end
  end

  // A value accepted on a toggle edge waits for the next toggle.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_div        <= CNT_W'(DEFAULT_DIV);
      r_pend_div   <= '0;
      r_pend_valid <= 1'b0;
    end else if (w_xfer) begin
      r_pend_div   <= cfg_div;
      r_pend_valid <= 1'b1;
    end else if (r_pend_valid &&
                 (r_state == ST_IDLE || w_wrap)) begin
      r_div        <= r_pend_div;
      r_pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_tick    <= 1'b0;
      r_periods <= '0;
    end else begin
      r_tick    <= w_wrap;
      r_periods <= r_periods + PER_W'(w_fall);
    end
  end

  assign cfg_ready = !r_pend_valid;
  assign running   = (r_state != ST_IDLE);
  assign clk_out   = w_clk;
  assign tick      = r_tick;
  assign periods   = r_periods;

endmodule

// File: tb/tb_clkdiv_sched.sv
// Directed self-checking bench for clkdiv_sched
// (DEFAULT_DIV=3, PER_W=4 to exercise wrap).
module tb_clkdiv_sched;

  localparam int CW = 8;
  localparam int PW = 4;

  logic          clk_in = 1'b0;
  logic          rst_n;
  logic          cfg_valid;
  logic [CW-1:0] cfg_div;
  logic          cfg_ready;
  logic          start;
  logic          stop;
  logic          running;
  logic          clk_out;
  logic          tick;
  logic [PW-1:0] periods;

  clkdiv_sched #(
    .CNT_W       (CW),
    .DEFAULT_DIV (3),
    .PER_W       (PW)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .start     (start),
    .stop      (stop),
    .running   (running),
    .clk_out   (clk_out),
    .tick      (tick),
    .periods   (periods)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic          s;
    logic          p;
    logic          cv;
    logic [CW-1:0] cd;
    logic          e_clk;
    logic          e_tick;
    logic          e_run;
    logic          e_rdy;
    logic [PW-1:0] e_per;
  } vec_t;

  vec_t tbl [29];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   t_last = 0;
  int   t_prev = 0;
  int   ticks  = 0;
  int   t0;
  logic ok;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic p,
                      input logic cv,
                      input logic [CW-1:0] cd);
    start = s;
    stop = p;
    cfg_valid = cv;
    cfg_div = cd;
    @(posedge clk_in);
    #1;
    cyc++;
    if (tick) begin
      ticks++;
      t_prev = t_last;
      t_last = cyc;
    end
  endtask

  task automatic wait_tick(input int bound,
                           output logic got);
    got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      step(0, 0, 0, 0);
      got = tick;
    end
    if (!got) chk("tick_timeout", 0, 1);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_run"}, int'(running), 0);
    chk({nm, "_clk"}, int'(clk_out), 0);
    chk({nm, "_tick"}, int'(tick), 0);
    chk({nm, "_per"}, int'(periods), 0);
    chk({nm, "_rdy"}, int'(cfg_ready), 1);
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 1, 1, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
    tbl[4]  = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    tbl[5]  = '{1, 0, 0, 0, 1, 0, 1, 1, 0};
    tbl[6]  = '{0, 0, 0, 0, 1, 0, 1, 1, 0};
    tbl[7]  = '{0, 0, 0, 0, 1, 0, 1, 1, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
    tbl[9]  = '{0, 0, 1, 1, 0, 0, 1, 0, 1};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 1, 0, 1};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 1, 0, 1};
    tbl[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
    tbl[13] = '{0, 0, 0, 0, 1, 0, 1, 1, 1};
    tbl[14] = '{0, 0, 0, 0, 0, 1, 1, 1, 2};
    tbl[15] = '{0, 0, 0, 0, 0, 0, 1, 1, 2};
    tbl[16] = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
    tbl[17] = '{0, 0, 0, 0, 1, 0, 1, 1, 2};
    tbl[18] = '{0, 0, 0, 0, 0, 1, 1, 1, 3};
    tbl[19] = '{0, 0, 0, 0, 0, 0, 1, 1, 3};
    tbl[20] = '{0, 0, 0, 0, 1, 1, 1, 1, 3};
    tbl[21] = '{0, 1, 0, 0, 1, 0, 1, 1, 3};
    tbl[22] = '{0, 0, 0, 0, 0, 1, 0, 1, 4};
    tbl[23] = '{0, 0, 0, 0, 0, 0, 0, 1, 4};
    tbl[24] = '{1, 1, 0, 0, 0, 0, 0, 1, 4};
    tbl[25] = '{1, 1, 0, 0, 0, 0, 0, 1, 4};
    tbl[26] = '{1, 0, 0, 0, 0, 0, 1, 1, 4};
    tbl[27] = '{0, 1, 0, 0, 0, 0, 0, 1, 4};
    tbl[28] = '{0, 0, 0, 0, 0, 0, 0, 1, 4};

    rst_n = 1'b0;
    start = 0;
    stop = 0;
    cfg_valid = 0;
    cfg_div = '0;
    repeat (2) @(posedge clk_in);
    #1;
    chk_reset("rst0");
    rst_n = 1'b1;

    for (int i = 0; i < 29; i++) begin
      step(tbl[i].s, tbl[i].p, tbl[i].cv, tbl[i].cd);
      chk($sformatf("v%0d_clk", i), int'(clk_out),
          int'(tbl[i].e_clk));
      chk($sformatf("v%0d_tick", i), int'(tick),
          int'(tbl[i].e_tick));
      chk($sformatf("v%0d_run", i), int'(running),
          int'(tbl[i].e_run));
      chk($sformatf("v%0d_rdy", i), int'(cfg_ready),
          int'(tbl[i].e_rdy));
      chk($sformatf("v%0d_per", i), int'(periods),
          int'(tbl[i].e_per));
    end

    // Start + transfer (5), then 7 held off, div now 1
    step(1, 0, 1, 5);
    chk("a0_rdy", int'(cfg_ready), 0);
    chk("a0_run", int'(running), 1);
    step(0, 0, 1, 7);
    chk("a1_rdy", int'(cfg_ready), 0);
    chk("a1_tick", int'(tick), 0);
    step(0, 0, 1, 7);
    chk("a2_tick", int'(tick), 1);
    chk("a2_clk", int'(clk_out), 1);
    chk("a2_rdy", int'(cfg_ready), 1);
    step(0, 0, 1, 7);
    chk("a3_rdy", int'(cfg_ready), 0);
    wait_tick(20, ok);
    chk("a_half5", t_last - t_prev, 6);
    chk("a_rdy_after", int'(cfg_ready), 1);
    wait_tick(20, ok);
    chk("a_half7", t_last - t_prev, 8);
    chk("a_clk", int'(clk_out), 1);
    chk("a_per", int'(periods), 5);

    step(0, 0, 1, 9);
    chk("d_rdy", int'(cfg_ready), 0);
    rst_n = 1'b0;
    #1;
    chk_reset("rst_async");
    @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    step(1, 0, 0, 0);
    t0 = cyc;
    wait_tick(20, ok);
    chk("d_first", t_last - t0, 4);
    wait_tick(20, ok);
    chk("d_half", t_last - t_prev, 4);
    chk("d_per", int'(periods), 1);

    rst_n = 1'b0;
    @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    step(0, 0, 1, 0);
    chk("w_rdy0", int'(cfg_ready), 0);
    chk("w_idle", int'(running), 0);
    step(0, 0, 0, 0);
    chk("w_rdy1", int'(cfg_ready), 1);
    step(1, 0, 0, 0);
    ticks = 0;
    for (int i = 0; i < 30; i++) wait_tick(5, ok);
    chk("w_div0", t_last - t_prev, 1);
    chk("w_per15", int'(periods), 15);
    wait_tick(5, ok);
    wait_tick(5, ok);
    chk("w_wrap", int'(periods), 0);
    chk("w_clk", int'(clk_out), 0);
    chk("w_ticks", ticks, 32);
    step(0, 1, 0, 0);
    chk("w_stop_run", int'(running), 0);
    chk("w_stop_tick", int'(tick), 0);
    step(0, 0, 0, 0);
    chk("w_idle_tick", int'(tick), 0);
    chk("w_idle_clk", int'(clk_out), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
